// File: rtl/cgra_cfg_loader.sv
// Fetches a configuration image over an OBI read port and streams it to the CGRA through a
// small FIFO. A credit check on OBI requests guarantees every read response finds FIFO space.
module cgra_cfg_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             obi_req_o,
  output logic [31:0]      obi_addr_o,
  output logic             obi_we_o,
  output logic [3:0]       obi_be_o,
  output logic [31:0]      obi_wdata_o,
  input  logic             obi_gnt_i,
  input  logic             obi_rvalid_i,
  input  logic [31:0]      obi_rdata_i,
  output logic             cfg_valid_o,
  output logic [31:0]      cfg_data_o,
  output logic             cfg_last_o,
  input  logic             cfg_ready_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [LEN_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [LEN_W-1:0]  pop_cnt_q, pop_cnt_d;
  logic [CntW-1:0]   outst_q, outst_d;
  logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic              req_hold_q, req_hold_d;
  logic              done_q, done_d;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic              active;
  logic              credit_ok;
  logic              req;
  logic              gnt_fire;
  logic              push;
  logic              pop;
  logic              fifo_nempty;
  logic [CntW:0]     credit_sum;

  assign active      = (state_q != StIdle);
  assign fifo_nempty = (fifo_cnt_q != '0);
  assign credit_sum  = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign credit_ok   = (credit_sum < (CntW + 1)'(FIFO_DEPTH));
  // A pending request is held until granted even if credit later looks short.
  assign req         = (state_q == StFetch) && (issue_cnt_q != '0) && (req_hold_q || credit_ok);
  assign gnt_fire    = req && obi_gnt_i;
  assign push        = active && obi_rvalid_i;
  assign pop         = fifo_nempty && cfg_ready_i;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    outst_d     = outst_q;
    fifo_cnt_d  = fifo_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    req_hold_d  = req && !obi_gnt_i;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_d      = base_addr_i & ~32'd3;
            issue_cnt_d = len_i;
            pop_cnt_d   = len_i;
            state_d     = StFetch;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (gnt_fire && (issue_cnt_q == LEN_W'(1))) state_d = StDrain;
      end
      StDrain: ;
      default: state_d = StIdle;
    endcase

    if (gnt_fire) begin
      addr_d      = addr_q + 32'd4;
      issue_cnt_d = issue_cnt_q - LEN_W'(1);
    end

    if (active && pop) begin
      pop_cnt_d = pop_cnt_q - LEN_W'(1);
      if (pop_cnt_q == LEN_W'(1)) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end

    case ({gnt_fire, push})
      2'b10:   outst_d = outst_q + CntW'(1);
      2'b01:   outst_d = outst_q - CntW'(1);
      default: outst_d = outst_q;
    endcase

    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      outst_q     <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_hold_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      outst_q     <= outst_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_hold_q  <= req_hold_d;
      done_q      <= done_d;
    end
  end

  // Storage needs no reset: it is only observed through fifo_cnt_q.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= obi_rdata_i;
  end

  assign busy_o      = active;
  assign done_o      = done_q;
  assign obi_req_o   = req;
  assign obi_addr_o  = addr_q;
  assign obi_we_o    = 1'b0;
  assign obi_be_o    = 4'b1111;
  assign obi_wdata_o = '0;
  assign cfg_valid_o = fifo_nempty;
  assign cfg_data_o  = fifo_nempty ? mem_q[rd_ptr_q] : '0;
  assign cfg_last_o  = fifo_nempty && (pop_cnt_q == LEN_W'(1));

endmodule

// File: tb/tb_cgra_cfg_loader.sv
// Scoreboard bench for cgra_cfg_loader: a random-latency OBI memory model feeds the DUT and a
// negedge monitor checks addresses, streamed words, holds, credit bound and done pulses.
module tb_cgra_cfg_loader;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LEN_W      = 10;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [31:0]      base_addr_i = '0;
  logic [LEN_W-1:0] len_i = '0;
  logic             busy_o, done_o;
  logic             obi_req_o, obi_we_o;
  logic [31:0]      obi_addr_o, obi_wdata_o;
  logic [3:0]       obi_be_o;
  logic             obi_gnt_i = 1'b0;
  logic             obi_rvalid_i = 1'b0;
  logic [31:0]      obi_rdata_i = '0;
  logic             cfg_valid_o, cfg_last_o;
  logic [31:0]      cfg_data_o;
  logic             cfg_ready_i = 1'b0;

  always #5 clk = ~clk;

  cgra_cfg_loader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .obi_req_o(obi_req_o), .obi_addr_o(obi_addr_o),
    .obi_we_o(obi_we_o), .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o),
    .obi_gnt_i(obi_gnt_i), .obi_rvalid_i(obi_rvalid_i), .obi_rdata_i(obi_rdata_i),
    .cfg_valid_o(cfg_valid_o), .cfg_data_o(cfg_data_o), .cfg_last_o(cfg_last_o),
    .cfg_ready_i(cfg_ready_i)
  );

  typedef struct packed {logic [31:0] data; logic last;} item_t;

  item_t       exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] rsp_q[$];

  int gnt_pct = 100, rv_pct = 100, rdy_pct = 100;
  int checks = 0, errors = 0;
  int done_cnt = 0, outst = 0, fill = 0, grants_x = 0;

  logic        prev_hold = 1'b0, prev_last = 1'b0, prev_req_wait = 1'b0;
  logic [31:0] prev_data = '0, prev_addr = '0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DEF00D;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Memory-side responder: random grant, in-order responses with random delay.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        cfg_ready_i  = 1'b0;
      end else begin
        obi_gnt_i = obi_req_o && ($urandom_range(99) < gnt_pct);
        if (rsp_q.size() > 0 && $urandom_range(99) < rv_pct) begin
          obi_rvalid_i = 1'b1;
          obi_rdata_i  = mem_fn(rsp_q[0]);
        end else begin
          obi_rvalid_i = 1'b0;
          obi_rdata_i  = $urandom;
        end
        cfg_ready_i = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  // Monitor: sees the values the DUT will act on at the next rising edge.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_hold     = 1'b0;
      prev_req_wait = 1'b0;
    end else begin
      if (prev_hold) begin
        check1("cfg_hold_valid", cfg_valid_o, 1'b1);
        check32("cfg_hold_data", cfg_data_o, prev_data);
        check1("cfg_hold_last", cfg_last_o, prev_last);
      end
      if (cfg_valid_o && cfg_ready_i) begin
        if (exp_q.size() == 0) begin
          check1("cfg_extra_word", cfg_valid_o, 1'b0);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          check32("cfg_data", cfg_data_o, it.data);
          check1("cfg_last", cfg_last_o, it.last);
          fill--;
        end
      end
      prev_hold = cfg_valid_o && !cfg_ready_i;
      prev_data = cfg_data_o;
      prev_last = cfg_last_o;

      if (prev_req_wait) begin
        check1("obi_req_held", obi_req_o, 1'b1);
        check32("obi_addr_held", obi_addr_o, prev_addr);
      end
      if (obi_req_o) begin
        check1("req_only_when_busy", busy_o, 1'b1);
        if (obi_gnt_i) begin
          if (exp_addr_q.size() == 0) begin
            check1("obi_extra_grant", obi_req_o, 1'b0);
          end else begin
            check32("obi_addr", obi_addr_o, exp_addr_q.pop_front());
          end
          rsp_q.push_back(obi_addr_o);
          outst++;
          grants_x++;
          check1("credit_bound", (outst + fill) <= FIFO_DEPTH, 1'b1);
        end
      end
      prev_req_wait = obi_req_o && !obi_gnt_i;
      prev_addr     = obi_addr_o;

      if (obi_rvalid_i && rsp_q.size() > 0) begin
        void'(rsp_q.pop_front());
        outst--;
        fill++;
      end
      if (done_o) begin
        done_cnt++;
        check1("busy_low_at_done", busy_o, 1'b0);
      end
    end
  end

  task automatic flush_model();
    exp_q.delete();
    exp_addr_q.delete();
    rsp_q.delete();
    outst = 0;
    fill  = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1 rst_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_done", done_o, 1'b0);
    check1("rst_req", obi_req_o, 1'b0);
    check32("rst_addr", obi_addr_o, 32'h0);
    check1("rst_we", obi_we_o, 1'b0);
    check32("rst_wdata", obi_wdata_o, 32'h0);
    check1("rst_cfg_valid", cfg_valid_o, 1'b0);
    check32("rst_cfg_data", cfg_data_o, 32'h0);
    check1("rst_cfg_last", cfg_last_o, 1'b0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    flush_model();
  endtask

  task automatic start_xfer(input logic [31:0] base, input int len);
    @(posedge clk);
    #1;
    start_i     = 1'b1;
    base_addr_i = base;
    len_i       = LEN_W'(len);
    grants_x    = 0;
    for (int i = 0; i < len; i++) begin
      logic [31:0] a;
      item_t       it;
      a       = (base & ~32'd3) + 32'(4 * i);
      it.data = mem_fn(a);
      it.last = (i == len - 1);
      exp_addr_q.push_back(a);
      exp_q.push_back(it);
    end
    @(posedge clk);
    #1 start_i = 1'b0;
    @(negedge clk);
    check1("busy_after_start", busy_o, len != 0);
    check1("req_after_start", obi_req_o, len != 0);
    check1("done_after_start", done_o, len == 0);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int c;
    c = 0;
    while (done_cnt == d0 && c < budget) begin
      @(posedge clk);
      c++;
    end
    check32("done_seen", 32'(done_cnt), 32'(d0 + 1));
    repeat (3) @(posedge clk);
    check32("single_done", 32'(done_cnt), 32'(d0 + 1));
    check32("words_left", 32'(exp_q.size()), 32'd0);
    check32("addrs_left", 32'(exp_addr_q.size()), 32'd0);
    @(negedge clk);
    check1("idle_after_done", busy_o, 1'b0);
    if (c >= budget) apply_reset();
  endtask

  task automatic run_xfer(input logic [31:0] base, input int len, input int budget);
    int d0;
    d0 = done_cnt;
    start_xfer(base, len);
    wait_done(d0, budget);
  endtask

  initial begin
    int d0;
    apply_reset();

    // Basic fetch with a fast memory and an always-ready sink.
    run_xfer(32'h0000_1000, 3, 100);

    // Zero-length transfer: done only.
    run_xfer(32'h0000_5000, 0, 10);

    // Address wrap-around, and ignored low address bits.
    run_xfer(32'hFFFF_FFF8, 3, 100);
    run_xfer(32'h0000_2003, 2, 100);

    // Back-pressure: grants stop once the credit is used up.
    rdy_pct = 0;
    d0 = done_cnt;
    start_xfer(32'h0000_2000, 8);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check32("bp_grants", 32'(grants_x), 32'(FIFO_DEPTH));
    check1("bp_req_low", obi_req_o, 1'b0);
    rdy_pct = 100;
    wait_done(d0, 200);

    // Grant stall: request and address hold while the grant is withheld.
    gnt_pct = 0;
    d0 = done_cnt;
    start_xfer(32'h0000_4000, 4);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check1("stall_req", obi_req_o, 1'b1);
    check32("stall_addr", obi_addr_o, 32'h0000_4000);
    gnt_pct = 100;
    wait_done(d0, 200);

    // Start while busy is ignored.
    gnt_pct = 60; rv_pct = 60; rdy_pct = 60;
    d0 = done_cnt;
    start_xfer(32'h0000_6000, 12);
    repeat (3) @(posedge clk);
    #1;
    start_i = 1'b1; base_addr_i = 32'h0000_9000; len_i = LEN_W'(5);
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(d0, 1000);

    // Reset mid-fetch aborts without done, then a fresh transfer works.
    gnt_pct = 50;
    d0 = done_cnt;
    start_xfer(32'h0000_3000, 20);
    repeat (6) @(posedge clk);
    apply_reset();
    repeat (5) @(posedge clk);
    check32("no_done_after_abort", 32'(done_cnt), 32'(d0));
    run_xfer(32'h0000_7000, 5, 500);

    // Random stress.
    run_xfer($urandom, 1, 100);
    for (int t = 0; t < 5; t++) begin
      int len;
      gnt_pct = $urandom_range(100, 30);
      rv_pct  = $urandom_range(100, 30);
      rdy_pct = $urandom_range(100, 30);
      len     = $urandom_range(1023, 1);
      run_xfer($urandom, len, len * 40 + 200);
    end
    gnt_pct = 90; rv_pct = 90; rdy_pct = 90;
    run_xfer($urandom, 1023, 1023 * 40 + 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
